// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared encodings for the memory-access stage
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int WB_REG_W = 38;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // Undefined size encodings fall through to "not ok" so they are dropped like misaligned ops.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return 1'b1;
            F3_H, F3_HU: return ~lo[0];
            F3_W:        return lo == 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// load_align : selects the addressed lane of a load word and extends it
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// mem_access : pipeline MEM stage issuing data-memory requests with timeout
// Revision   : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_valid,
    input  logic                i_rd_we,
    input  logic [4:0]          i_rd,
    input  logic [31:0]         i_alu_result,
    input  logic [31:0]         i_store_data,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [2:0]          i_funct3,
    output logic                o_stall,
    output logic                o_dmem_req,
    output logic                o_dmem_we,
    output logic [31:0]         o_dmem_addr,
    output logic [31:0]         o_dmem_wdata,
    output logic [3:0]          o_dmem_be,
    input  logic                i_dmem_ready,
    input  logic [31:0]         i_dmem_rdata,
    output logic [WB_REG_W-1:0] o_wb_reg,
    output logic                o_misaligned,
    output logic                o_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e       state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             is_mem, ok, timed_out;
    logic             issue, misalign, complete, abort;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, load_data;
    logic [4:0]       rd_q;
    logic             rd_we_q;
    logic [2:0]       f3_q;

    assign is_mem    = i_mem_read | i_mem_write;
    assign ok        = access_ok(i_funct3, i_alu_result[1:0]);
    assign timed_out = (int'(cnt) + 1) >= TIMEOUT;

    always_comb begin
        next_state = state;
        issue      = 1'b0;
        misalign   = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (i_valid && is_mem) begin
                    if (ok) begin
                        issue      = 1'b1;
                        next_state = MEM_WAIT;
                    end else begin
                        misalign   = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (i_dmem_ready) begin
                    complete   = 1'b1;
                    next_state = MEM_IDLE;
                end else if (timed_out) begin
                    abort      = 1'b1;
                    next_state = MEM_IDLE;
                end
            end
            default: next_state = MEM_IDLE;
        endcase
    end

    assign o_stall = (state == MEM_WAIT) | issue;

    always_comb begin
        case (i_funct3[1:0])
            2'b00:   begin lane_be = 4'b0001 << i_alu_result[1:0]; lane_wdata = {4{i_store_data[7:0]}};  end
            2'b01:   begin lane_be = 4'b0011 << i_alu_result[1:0]; lane_wdata = {2{i_store_data[15:0]}}; end
            default: begin lane_be = 4'b1111;                      lane_wdata = i_store_data;            end
        endcase
    end

    load_align u_load_align (
        .rdata   (i_dmem_rdata),
        .addr_lo (o_dmem_addr[1:0]),
        .funct3  (f3_q),
        .result  (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= MEM_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_dmem_req   <= 1'b0;
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_wdata <= '0;
            o_dmem_be    <= '0;
            o_wb_reg     <= '0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            cnt          <= '0;
            rd_q         <= '0;
            rd_we_q      <= 1'b0;
            f3_q         <= '0;
        end else begin
            o_misaligned <= misalign;
            o_bus_err    <= abort;
            if (issue) begin
                o_dmem_req   <= 1'b1;
                o_dmem_we    <= i_mem_write;
                o_dmem_addr  <= i_alu_result;
                o_dmem_be    <= lane_be;
                o_dmem_wdata <= lane_wdata;
                cnt          <= '0;
                rd_q         <= i_rd;
                rd_we_q      <= i_rd_we && (i_rd != 5'd0);
                f3_q         <= i_funct3;
            end else if (state == MEM_WAIT && !i_dmem_ready) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (complete || abort) begin
                o_dmem_req <= 1'b0;
            end
            // Only ALU results and completed loads write back; every other event just clears the enable.
            if (complete && !o_dmem_we) begin
                o_wb_reg <= {rd_we_q, rd_q, load_data};
            end else if (state == MEM_IDLE && i_valid && !is_mem) begin
                o_wb_reg <= {i_rd_we && (i_rd != 5'd0), i_rd, i_alu_result};
            end else begin
                o_wb_reg[WB_REG_W-1] <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// tb_mem_access : directed self-checking bench for mem_access
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        valid = 1'b0, rd_we = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [4:0]  rd = '0;
    logic [31:0] alu_result = '0, store_data = '0, dmem_rdata = '0;
    logic [2:0]  funct3 = '0;
    logic        dmem_ready = 1'b0;
    logic        stall, dmem_req, dmem_we, misaligned, bus_err;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [37:0] wb_reg;

    int tests = 0;
    int fails = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(TB_TIMEOUT)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_rd_we(rd_we), .i_rd(rd),
        .i_alu_result(alu_result), .i_store_data(store_data), .i_mem_read(mem_read),
        .i_mem_write(mem_write), .i_funct3(funct3), .o_stall(stall), .o_dmem_req(dmem_req),
        .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata),
        .o_dmem_be(dmem_be), .i_dmem_ready(dmem_ready), .i_dmem_rdata(dmem_rdata),
        .o_wb_reg(wb_reg), .o_misaligned(misaligned), .o_bus_err(bus_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
        return (a % acc_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        v = ((1 << acc_size(f3)) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (acc_size(f3) == 1) return d[7:0] * 32'h0101_0101;
        if (acc_size(f3) == 2) return d[15:0] * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
        longint v;
        int     bits;
        bits = 8 * acc_size(f3);
        v = longint'(w >> (8 * (a % 4)));
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (!f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        end
        return v[31:0];
    endfunction

    bit          m_busy, m_req, m_we, m_mis, m_err, m_rdwe;
    int          m_waits;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [37:0] m_wb;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy = 0; m_req = 0; m_we = 0; m_mis = 0; m_err = 0; m_rdwe = 0;
            m_waits = 0; m_addr = 0; m_wdata = 0; m_be = 0; m_wb = 0; m_rd = 0; m_f3 = 0;
        end else begin
            m_mis = 0;
            m_err = 0;
            if (m_busy) begin
                if (dmem_ready) begin
                    m_busy = 0;
                    m_req  = 0;
                    if (!m_we) m_wb = {m_rdwe && m_rd != 0, m_rd, exp_load(dmem_rdata, m_addr, m_f3)};
                end else begin
                    m_waits++;
                    if (m_waits == TB_TIMEOUT) begin
                        m_busy = 0; m_req = 0; m_err = 1;
                    end
                end
            end else if (valid && (mem_read || mem_write)) begin
                m_wb[37] = 1'b0;
                if (legal(funct3, alu_result)) begin
                    m_busy = 1; m_req = 1; m_we = mem_write; m_addr = alu_result;
                    m_be = exp_be(funct3, alu_result); m_wdata = exp_wdata(funct3, store_data);
                    m_rd = rd; m_rdwe = rd_we; m_f3 = funct3; m_waits = 0;
                end else begin
                    m_mis = 1;
                end
            end else if (valid) begin
                m_wb = {rd_we && rd != 0, rd, alu_result};
            end else begin
                m_wb[37] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("stall", stall, m_busy || (valid && (mem_read || mem_write) && legal(funct3, alu_result)));
            chk("dmem_req", dmem_req, m_req);
            chk("wb_reg", wb_reg, m_wb);
            chk("misaligned", misaligned, m_mis);
            chk("bus_err", bus_err, m_err);
            if (m_req) begin
                chk("dmem_we", dmem_we, m_we);
                chk("dmem_addr", dmem_addr, m_addr);
                chk("dmem_be", dmem_be, m_be);
                chk("dmem_wdata", dmem_wdata, m_wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic alu_op(input logic we, input logic [4:0] r, input logic [31:0] res);
        valid = 1; rd_we = we; rd = r; alu_result = res; mem_read = 0; mem_write = 0;
        @(posedge clk); #1;
        valid = 0;
    endtask

    // ready_at: WAIT cycle (1-based) in which memory answers; -1 never answers.
    task automatic mem_op(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] r, input logic [31:0] rdata,
                          input int ready_at, output int stall_cnt, output int wait_cnt,
                          output logic [3:0] cap_be, output logic [31:0] cap_wdata, output logic cap_we);
        bit done;
        valid = 1; mem_read = ld; mem_write = ~ld; funct3 = f3; alu_result = addr;
        store_data = sdata; rd = r; rd_we = ld; dmem_rdata = rdata; dmem_ready = 0;
        stall_cnt = 0; wait_cnt = 0; done = 0;
        cap_be = 'x; cap_wdata = 'x; cap_we = 'x;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            @(posedge clk); #1;
            if (c == 0) begin
                cap_be = dmem_be; cap_wdata = dmem_wdata; cap_we = dmem_we;
            end
            if (!m_busy) begin
                done = 1;
                break;
            end
            wait_cnt++;
            dmem_ready = (wait_cnt == ready_at);
        end
        if (!done) chk("op_done", 0, 1);
        valid = 0; mem_read = 0; mem_write = 0; dmem_ready = 0;
    endtask

    int          sc, wc;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic        we_c;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_wb", wb_reg, 0);
        chk("reset_req", dmem_req, 0);
        @(negedge clk);
        rstn = 1;
        checking = 1;
        @(posedge clk); #1;

        // ALU write-back, one-cycle latency
        valid = 1; rd_we = 1; rd = 5'd5; alu_result = 32'h0000_1234;
        #1 chk("alu_stall", stall, 0);
        @(posedge clk); #1;
        valid = 0;
        chk("alu_wb", wb_reg, {1'b1, 5'd5, 32'h0000_1234});
        alu_op(1'b1, 5'd0, 32'hCAFE_0000);
        alu_op(1'b0, 5'd9, 32'h0000_0042);
        @(posedge clk); #1;

        // ready while idle must be ignored
        dmem_ready = 1;
        @(posedge clk); #1;
        dmem_ready = 0;
        chk("idle_ready_req", dmem_req, 0);

        // LB from the top byte lane, sign-extended
        mem_op(1, 3'b000, 32'h0000_0103, 0, 5'd7, 32'h80AA_BBCC, 3, sc, wc, be_c, wd_c, we_c);
        chk("lb_be", be_c, 4'b1000);
        chk("lb_we", we_c, 0);
        chk("lb_stall_cycles", sc, 4);
        chk("lb_wb", wb_reg, {1'b1, 5'd7, 32'hFFFF_FF80});

        // SH upper half
        mem_op(0, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 5'd3, 0, 1, sc, wc, be_c, wd_c, we_c);
        chk("sh_be", be_c, 4'b1100);
        chk("sh_wdata", wd_c, 32'hBEEF_BEEF);
        chk("sh_we", we_c, 1);
        chk("sh_wb_we", wb_reg[37], 0);

        // misaligned LW: dropped, single pulse
        mem_op(1, 3'b010, 32'h0000_0101, 0, 5'd4, 0, 1, sc, wc, be_c, wd_c, we_c);
        chk("lw_mis_pulse", misaligned, 1);
        chk("lw_mis_req", dmem_req, 0);
        chk("lw_mis_stall", sc, 0);
        @(posedge clk); #1;
        chk("lw_mis_pulse_end", misaligned, 0);

        // more lanes and sizes
        mem_op(1, 3'b001, 32'h0000_0102, 0, 5'd8, 32'h8001_7FFF, 2, sc, wc, be_c, wd_c, we_c);
        chk("lh_wb", wb_reg[31:0], 32'hFFFF_8001);
        mem_op(1, 3'b101, 32'h0000_0100, 0, 5'd8, 32'h1234_F00D, 1, sc, wc, be_c, wd_c, we_c);
        chk("lhu_wb", wb_reg[31:0], 32'h0000_F00D);
        mem_op(1, 3'b100, 32'h0000_0101, 0, 5'd10, 32'h1234_56AB, 1, sc, wc, be_c, wd_c, we_c);
        chk("lbu_wb", wb_reg[31:0], 32'h0000_0056);
        chk("lbu_be", be_c, 4'b0010);
        mem_op(1, 3'b010, 32'h0000_0104, 0, 5'd0, 32'hDEAD_BEEF, 1, sc, wc, be_c, wd_c, we_c);
        chk("lw_rd0_wb", wb_reg, {1'b0, 5'd0, 32'hDEAD_BEEF});
        mem_op(0, 3'b000, 32'h0000_0201, 32'h0000_125A, 5'd1, 0, 2, sc, wc, be_c, wd_c, we_c);
        chk("sb_be", be_c, 4'b0010);
        chk("sb_wdata", wd_c, 32'h5A5A_5A5A);
        mem_op(0, 3'b010, 32'h0000_0300, 32'h0102_0304, 5'd1, 0, 1, sc, wc, be_c, wd_c, we_c);
        chk("sw_be", be_c, 4'b1111);
        mem_op(1, 3'b011, 32'h0000_0100, 0, 5'd2, 0, 1, sc, wc, be_c, wd_c, we_c);
        chk("undef_f3_mis", misaligned, 1);
        mem_op(1, 3'b001, 32'h0000_0101, 0, 5'd2, 0, 1, sc, wc, be_c, wd_c, we_c);
        chk("lh_odd_mis", misaligned, 1);

        // timeout abort
        mem_op(1, 3'b010, 32'h0000_0200, 0, 5'd6, 0, -1, sc, wc, be_c, wd_c, we_c);
        chk("timeout_wait_cycles", wc, TB_TIMEOUT);
        chk("timeout_bus_err", bus_err, 1);
        chk("timeout_req", dmem_req, 0);
        @(posedge clk); #1;
        chk("timeout_pulse_end", bus_err, 0);

        // reset in the middle of a WAIT, then a late ready
        valid = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; alu_result = 32'h0000_0204;
        rd = 5'd11; rd_we = 1; dmem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_reset_req", dmem_req, 1);
        rstn = 0; valid = 0; mem_read = 0;
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_wb", wb_reg, 0);
        @(negedge clk);
        rstn = 1;
        @(posedge clk); #1;
        dmem_ready = 1;
        @(posedge clk); #1;
        dmem_ready = 0;
        @(posedge clk); #1;
        chk("post_rst_wb", wb_reg, 0);
        chk("post_rst_req", dmem_req, 0);

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waiting for o_dmem_req acknowledge before abort.
REQ-002 i_clk  input  1  clock; all state on rising edge.
REQ-003 i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 i_valid  input  1  EX/MEM entry present.
REQ-005 i_rd_we  input  1  instruction writes rd.
REQ-006 i_rd  input  5  destination register.
REQ-007 i_alu_result  input  32  ALU result or effective address.
REQ-008 i_store_data  input  32  rs2 value for stores.
REQ-009 i_mem_read  input  1  load.
REQ-010 i_mem_write  input  1  store.
REQ-011 i_funct3  input  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-012 o_stall  output  1  upstream holds all i_* inputs while high.
REQ-013 o_dmem_req  output  1  data memory request.
REQ-014 o_dmem_we  output  1  write request.
REQ-015 o_dmem_addr  output  32  byte address.
REQ-016 o_dmem_wdata  output  32  store data, lane-replicated.
REQ-017 o_dmem_be  output  4  byte enables.
REQ-018 i_dmem_ready  input  1  request accepted/complete; i_dmem_rdata valid same cycle.
REQ-019 i_dmem_rdata  input  32  load word.
REQ-020 o_wb_reg  output  38  {we[37], rd[36:32], result[31:0]} to write-back stage.
REQ-021 o_misaligned  output  1  one-cycle pulse, misaligned access dropped.
REQ-022 o_bus_err  output  1  one-cycle pulse, TIMEOUT expired.

Function
REQ-023 FSM states IDLE, WAIT; all outputs except o_stall registered.
REQ-024 IDLE, i_valid, no mem op: next edge o_wb_reg = {i_rd_we && i_rd!=0, i_rd, i_alu_result}; 1-cycle latency.
REQ-025 IDLE, i_valid, aligned mem op: next edge o_dmem_req=1, addr/we/be/wdata loaded, timeout counter cleared, state->WAIT, o_wb_reg[37]=0.
REQ-026 o_stall = (state==WAIT) | (state==IDLE & i_valid & (i_mem_read|i_mem_write) & aligned), combinational.
REQ-027 WAIT: request fields held stable until the edge sampling i_dmem_ready=1; then o_dmem_req=0, state->IDLE, o_wb_reg written.
REQ-028 Load completion: o_wb_reg = {i_rd_we && i_rd!=0, i_rd, extracted data}; store completion: o_wb_reg[37]=0.
REQ-029 Load extract: lane = addr[1:0]; B/H sign-extend, BU/HU zero-extend, W full word.
REQ-030 Store: SB be=0001<<addr[1:0], wdata={4{byte}}; SH be=0011<<addr[1:0], wdata={2{half}}; SW be=1111.
REQ-031 Loads drive o_dmem_be per REQ-030 size rules, o_dmem_we=0.
REQ-032 Misaligned: H with addr[0]=1, W with addr[1:0]!=0; no request, o_misaligned=1 one cycle, o_wb_reg[37]=0, no stall.
REQ-033 Undefined funct3 (011,110,111) on mem op: treated as misaligned.
REQ-034 WAIT counter reaches TIMEOUT without ready: o_dmem_req=0, o_bus_err=1 one cycle, o_wb_reg[37]=0, state->IDLE.
REQ-035 i_dmem_ready in IDLE ignored.
REQ-036 i_valid=0 in IDLE: o_wb_reg[37]=0, rest of o_wb_reg hold.

Reset
REQ-037 Asserting i_rstn low forces IDLE, o_wb_reg=0, o_dmem_req=0, o_dmem_we=0, addr/wdata=0, be=0, pulses=0, counter=0; mid-WAIT request dropped, no completion emitted.

Structure
REQ-038 Shared package riscv_pkg: funct3 encodings, WB_REG_W=38, mem FSM state enum.
REQ-039 One combinational sub-module load_align (rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-040 ADD result 0x0000_1234, rd=5, rd_we=1 -> next edge o_wb_reg = {1,5,0x0000_1234}, o_stall=0.
REQ-041 LB addr 0x103, rdata 0x80AA_BBCC, ready after 3 cycles -> be=1000, o_stall high 4 cycles, result 0xFFFF_FF80.
REQ-042 SH addr 0x102, store_data 0x0000_BEEF -> be=1100, wdata 0xBEEF_BEEF, we=1, o_wb_reg[37]=0.
REQ-043 LW addr 0x101 -> no o_dmem_req, o_misaligned one pulse, o_stall=0.
REQ-044 TIMEOUT=4, LW addr 0x200, ready never -> o_bus_err after 4 WAIT cycles, req drops, IDLE.
REQ-045 i_rstn low during WAIT, then ready pulses -> o_dmem_req=0, o_wb_reg=0, no write emitted.
